// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - N-way WIDTH-bit selector with two-entry registered output buffer
// Optional select range checker enabled by MUXN_PIPE_SELCHK_EN.
module muxn_pipe #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    parameter int SELW = 2,
    parameter logic [WIDTH-1:0] DEFVAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   y,
    output logic [SELW-1:0]    sel_q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err,
    output logic [7:0]         err_cnt
);
    logic [1:0]       cnt, cnt_nxt;
    logic             rdy_q, ov_q;
    logic [WIDTH-1:0] head_d, tail_d, din;
    logic [SELW-1:0]  head_s, tail_s;
    logic             push, pop;

    // Out-of-range selects fall through to DEFVAL.
    always_comb begin
        din = DEFVAL;
        for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i)) din = d[i*WIDTH +: WIDTH];
        end
    end

    assign in_ready  = rdy_q & ~reset;
    assign out_valid = ov_q;
    assign y         = head_d;
    assign sel_q     = head_s;
    assign push      = in_valid & in_ready;
    assign pop       = ov_q & out_ready;

    always_comb begin
        cnt_nxt = cnt;
        if (flush)
            cnt_nxt = 2'd0;
        else if (push && !pop)
            cnt_nxt = cnt + 2'd1;
        else if (pop && !push)
            cnt_nxt = cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 2'd0;
            rdy_q  <= 1'b1;
            ov_q   <= 1'b0;
            head_d <= '0;
            head_s <= '0;
            tail_d <= '0;
            tail_s <= '0;
        end else begin
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt != 2'd2);
            ov_q  <= (cnt_nxt != 2'd0);
            if (!flush) begin
                // A simultaneous push/pop only happens at cnt=1, so the new entry becomes head.
                if (push && (cnt == 2'd0 || pop)) begin
                    head_d <= din;
                    head_s <= sel;
                end else if (pop) begin
                    head_d <= tail_d;
                    head_s <= tail_s;
                end
                if (push && !pop && cnt == 2'd1) begin
                    tail_d <= din;
                    tail_s <= sel;
                end
            end
        end
    end

`ifdef MUXN_PIPE_SELCHK_EN
    logic       err_q;
    logic [7:0] err_cnt_q;
    logic       oor;

    assign oor     = (32'(sel) >= 32'(N));
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q <= push & oor & ~flush;
            if (push && oor && !flush && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule
